// File: rtl/wb_mem_pkg.sv
// rtl/wb_mem_pkg.sv - shared types and constants for the Wishbone memory responder
package wb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } wb_mem_state_t;

   localparam int LANE_LO  = 0;
   localparam int LANE_HI  = 1;
   localparam int WB_DAT_W = 16;
   localparam int WB_ADR_W = 15;

   // Any address bit above the implemented range marks the access out of range.
   function automatic logic addr_out_of_range(input logic [WB_ADR_W-1:0] adr, input int aw);
      logic [WB_ADR_W-1:0] hi_mask;
      hi_mask = ~((WB_ADR_W'(1) << aw) - WB_ADR_W'(1));
      return |(adr & hi_mask);
   endfunction

endpackage

// File: rtl/wb_mem_array.sv
// rtl/wb_mem_array.sv - single-port 16-bit RAM with per-lane write enable and registered read
module wb_mem_array
   import wb_mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [1:0]            lane_we,
   input  logic [WB_DAT_W-1:0]   wdata,
   input  logic                  rd_en,
   output logic [WB_DAT_W-1:0]   rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [WB_DAT_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (lane_we[LANE_LO]) mem[addr][7:0]  <= wdata[7:0];
      if (lane_we[LANE_HI]) mem[addr][15:8] <= wdata[15:8];
      if (rd_en)            rdata           <= mem[addr];
   end

endmodule

// File: rtl/wb_memory_responder.sv
// rtl/wb_memory_responder.sv - classic Wishbone RAM slave with wait states and out-of-range error
module wb_memory_responder
   import wb_mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                cyc_i,
   input  logic                stb_i,
   input  logic                we_i,
   input  logic [1:0]          sel_i,
   input  logic [WB_ADR_W-1:0] adr_i,
   input  logic [WB_DAT_W-1:0] dat_i,
   output logic                ack_o,
   output logic                err_o,
   output logic [WB_DAT_W-1:0] dat_o,
   output logic [1:0]          state_o
);

   localparam logic [1:0] ST_IDLE = 2'(IDLE);
   localparam logic [1:0] ST_WAIT = 2'(WAIT);
   localparam logic [1:0] ST_RESP = 2'(RESP);
   localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);

   logic [1:0]            state_q;
   logic [3:0]            cnt_q;
   logic                  we_q;
   logic [1:0]            sel_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [WB_DAT_W-1:0]   dat_q;
   logic                  oor_q;
   logic                  ack_q;
   logic                  err_q;
   logic [1:0]            rmask_q;

   logic                  req;
   logic                  in_idle;
   logic                  cur_we;
   logic [1:0]            cur_sel;
   logic [ADDR_WIDTH-1:0] cur_adr;
   logic [WB_DAT_W-1:0]   cur_dat;
   logic                  cur_oor;
   logic                  complete;
   logic [1:0]            mem_we;
   logic                  mem_rd;
   logic [WB_DAT_W-1:0]   ram_rdata;

   assign req     = cyc_i & stb_i;
   assign in_idle = (state_q == ST_IDLE);

   // With zero wait states the completion edge is also the latching edge, so use live inputs.
   assign cur_we  = in_idle ? we_i                              : we_q;
   assign cur_sel = in_idle ? sel_i                             : sel_q;
   assign cur_adr = in_idle ? adr_i[ADDR_WIDTH-1:0]             : adr_q;
   assign cur_dat = in_idle ? dat_i                             : dat_q;
   assign cur_oor = in_idle ? addr_out_of_range(adr_i, ADDR_WIDTH) : oor_q;

   always_comb begin
      complete = 1'b0;
      if (rst_n_i && req) begin
         case (state_q)
            ST_IDLE: complete = (WAIT_STATES == 0);
            ST_WAIT: complete = (cnt_q == 4'd1);
            default: complete = 1'b0;
         endcase
      end
   end

   assign mem_we = (complete && cur_we && !cur_oor) ? cur_sel : 2'b00;
   assign mem_rd = complete && !cur_we && !cur_oor;

   wb_mem_array #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_array (
      .clk_i  (clk_i),
      .addr   (cur_adr),
      .lane_we(mem_we),
      .wdata  (cur_dat),
      .rd_en  (mem_rd),
      .rdata  (ram_rdata)
   );

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         we_q    <= 1'b0;
         sel_q   <= 2'b00;
         adr_q   <= '0;
         dat_q   <= '0;
         oor_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rmask_q <= 2'b00;
      end else begin
         ack_q <= 1'b0;
         err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req) begin
                  we_q  <= we_i;
                  sel_q <= sel_i;
                  adr_q <= adr_i[ADDR_WIDTH-1:0];
                  dat_q <= dat_i;
                  oor_q <= addr_out_of_range(adr_i, ADDR_WIDTH);
                  cnt_q <= WS_INIT;
                  state_q <= (WAIT_STATES == 0) ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (!req)
                  state_q <= ST_IDLE;
               else if (cnt_q == 4'd1)
                  state_q <= ST_RESP;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         if (complete) begin
            ack_q <= ~cur_oor;
            err_q <= cur_oor;
            if (cur_oor)
               rmask_q <= 2'b00;
            else if (!cur_we)
               rmask_q <= cur_sel;
         end
      end
   end

   // RAM output only changes on a read completion, so masking it keeps dat_o stable between responses.
   assign dat_o   = ram_rdata & {{8{rmask_q[LANE_HI]}}, {8{rmask_q[LANE_LO]}}};
   assign ack_o   = ack_q;
   assign err_o   = err_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_wb_memory_responder.sv
// tb/tb_wb_memory_responder.sv - randomized self-checking bench for wb_memory_responder
module tb_wb_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cyc  [3];
   logic        stb  [3];
   logic        we   [3];
   logic [1:0]  sel  [3];
   logic [14:0] adr  [3];
   logic [15:0] dati [3];
   logic        ack  [3];
   logic        err  [3];
   logic [15:0] dato [3];
   logic [1:0]  st   [3];

   logic [15:0] mdl [3][1024];
   int          n_checks = 0;
   int          n_err    = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      wb_memory_responder #(
         .ADDR_WIDTH (10),
         .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
      ) u_dut (
         .clk_i  (clk),
         .rst_n_i(rst_n),
         .cyc_i  (cyc[g]),
         .stb_i  (stb[g]),
         .we_i   (we[g]),
         .sel_i  (sel[g]),
         .adr_i  (adr[g]),
         .dat_i  (dati[g]),
         .ack_o  (ack[g]),
         .err_o  (err[g]),
         .dat_o  (dato[g]),
         .state_o(st[g])
      );
   end

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : (d == 1) ? 1 : 3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic xfer(input int d, input logic w, input logic [1:0] s,
                       input logic [14:0] a, input logic [15:0] wd);
      int          lat;
      logic        got_ack;
      logic        got_err;
      logic [15:0] got_dat;
      logic        exp_err;
      logic [15:0] mask;
      @(posedge clk); #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; adr[d] = a; dati[d] = wd;
      lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = '0;
      while (!(got_ack || got_err) && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         got_ack = ack[d];
         got_err = err[d];
         got_dat = dato[d];
         if (!(got_ack || got_err) && ($urandom_range(1) == 1)) begin
            we[d] = 1'($urandom); sel[d] = 2'($urandom);
            adr[d] = 15'($urandom); dati[d] = 16'($urandom);
         end
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      exp_err = (a >= 15'd1024);
      mask = {{8{s[1]}}, {8{s[0]}}};
      check("latency", lat, ws_of(d) + 1);
      check("ack", got_ack, !exp_err);
      check("err", got_err, exp_err);
      if (exp_err)
         check("dat_oor", got_dat, 16'h0000);
      else if (!w)
         check("rdata", got_dat, mdl[d][a[9:0]] & mask);
      if (!exp_err && w)
         mdl[d][a[9:0]] = (mdl[d][a[9:0]] & ~mask) | (wd & mask);
      @(posedge clk); #1;
      check("pulse_len", {ack[d], err[d]}, 2'b00);
      check("dat_hold", dato[d], got_dat);
   endtask

   task automatic burst(input int d, input int len);
      int n_ack;
      int last;
      int period;
      int exp_n;
      period = ws_of(d) + 2;
      exp_n = 0;
      for (int k = 0; k * period + ws_of(d) + 1 <= len - 1; k++) exp_n++;
      @(posedge clk); #1;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = 1'b0; sel[d] = 2'b11; adr[d] = 15'h0005;
      n_ack = 0; last = -1;
      for (int c = 0; c < len; c++) begin
         if (ack[d]) begin
            n_ack++;
            check("b2b_dat", dato[d], mdl[d][5]);
            if (last >= 0) check("b2b_gap", c - last, period);
            else           check("b2b_first", c, ws_of(d) + 1);
            last = c;
         end
         @(posedge clk); #1;
      end
      cyc[d] = 1'b0; stb[d] = 1'b0;
      check("b2b_count", n_ack, exp_n);
      repeat (8) @(posedge clk);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          first [3];
      logic        seen;
      logic [15:0] old;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0; sel[d] = 2'b00; adr[d] = '0; dati[d] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b1; stb[d] = 1'b1; sel[d] = 2'b11;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_ack", ack[d], 1'b0);
         check("rst_err", err[d], 1'b0);
         check("rst_state", st[d], 2'd0);
         check("rst_dat", dato[d], 16'h0000);
         first[d] = -1;
      end
      rst_n = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++)
            if (first[d] < 0 && ack[d]) first[d] = k;
      end
      for (int d = 0; d < 3; d++) begin
         cyc[d] = 1'b0; stb[d] = 1'b0;
         check("first_ack", first[d], ws_of(d) + 1);
      end
      repeat (6) @(posedge clk);

      // Bring the region the bench touches to a known state.
      for (int d = 0; d < 3; d++)
         for (int a = 0; a < 32; a++) begin
            mdl[d][a] = 16'h0000;
            xfer(d, 1'b1, 2'b11, 15'(a), 16'h0000);
         end

      for (int d = 0; d < 3; d++) begin
         xfer(d, 1'b1, 2'b11, 15'h0005, 16'hBEEF);
         xfer(d, 1'b0, 2'b11, 15'h0005, 16'h0000);
         xfer(d, 1'b1, 2'b11, 15'h0006, 16'h1234);
         xfer(d, 1'b1, 2'b10, 15'h0006, 16'hAB00);
         xfer(d, 1'b0, 2'b11, 15'h0006, 16'h0000);
         xfer(d, 1'b0, 2'b01, 15'h0006, 16'h0000);
         xfer(d, 1'b1, 2'b00, 15'h0006, 16'h5A5A);
         xfer(d, 1'b0, 2'b11, 15'h0006, 16'h0000);
         xfer(d, 1'b0, 2'b00, 15'h0006, 16'h0000);
         xfer(d, 1'b1, 2'b11, 15'h0400, 16'h5555);
         xfer(d, 1'b0, 2'b11, 15'h0000, 16'h0000);
         xfer(d, 1'b0, 2'b11, 15'h0400, 16'h0000);
         xfer(d, 1'b0, 2'b11, 15'h7FFF, 16'h0000);
      end

      xfer(2, 1'b1, 2'b11, 15'h0010, 16'h0000);
      @(posedge clk); #1;
      cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; sel[2] = 2'b11; adr[2] = 15'h0010; dati[2] = 16'hFFFF;
      @(posedge clk); #1;
      check("abort_in_wait", st[2], 2'd1);
      @(posedge clk); #1;
      stb[2] = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (ack[2] || err[2]) seen = 1'b1;
      end
      check("abort_no_resp", seen, 1'b0);
      check("abort_idle", st[2], 2'd0);
      cyc[2] = 1'b0;
      xfer(2, 1'b0, 2'b11, 15'h0010, 16'h0000);

      for (int d = 0; d < 3; d++) burst(d, 20);

      xfer(1, 1'b0, 2'b11, 15'h0005, 16'h0000);
      old = mdl[1][7];
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 2'b11; adr[1] = 15'h0007; dati[1] = ~old;
      @(posedge clk); #1;
      check("rstx_in_wait", st[1], 2'd1);
      #2 rst_n = 1'b0;
      #1;
      check("rstx_state", st[1], 2'd0);
      check("rstx_ack", ack[1], 1'b0);
      check("rstx_err", err[1], 1'b0);
      check("rstx_dat", dato[1], 16'h0000);
      cyc[1] = 1'b0; stb[1] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      xfer(1, 1'b0, 2'b11, 15'h0007, 16'h0000);

      for (int d = 0; d < 3; d++)
         for (int i = 0; i < 80; i++) begin
            logic [14:0] a;
            a = ($urandom_range(7) == 0) ? 15'(1024 + $urandom_range(31743)) : 15'($urandom_range(31));
            xfer(d, 1'($urandom), 2'($urandom), a, 16'($urandom));
         end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
